axo_mem_arbiter: RTL



---
 rtl/axo_mem_arbiter.sv | 208 ++++++++++++++++++++
 1 files changed

// File: rtl/axo_mem_arbiter.sv
// axo_mem_arbiter: two-port req/ack arbiter in front of a shared aligned RAM bus.
//   Port 0 is the data (load/store) port and port 1 is the instruction-fetch port.
//   The arbiter grants one request at a time and issues one bus access for it.
//   It then waits the fixed RAM latency and returns the read data.
//   Misaligned accesses and the illegal access size are rejected without touching the bus.
// Optional feature macro: AXO_ARB_ROUND_ROBIN_EN
//   Defined   : round-robin arbitration on simultaneous requests.
//   Undefined : fixed priority, where port 0 always wins.
//
// Handshake: the requester raises rN_req and holds every rN_* input stable until it sees
// the one-cycle rN_ack pulse. At the edge that ends the ack cycle it may drop req or present
// a new request. rN_err and rN_rdata are valid only while rN_ack is high. A request is
// sampled only in IDLE, which always follows DONE, so a stale request is never granted twice.
module axo_mem_arbiter #(
  parameter int unsigned LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        r0_req,
  input  logic        r0_we,
  input  logic [1:0]  r0_asize,
  input  logic [31:0] r0_addr,
  input  logic [31:0] r0_wdata,
  output logic        r0_ack,
  output logic        r0_err,
  output logic [31:0] r0_rdata,
  input  logic        r1_req,
  input  logic        r1_we,
  input  logic [1:0]  r1_asize,
  input  logic [31:0] r1_addr,
  input  logic [31:0] r1_wdata,
  output logic        r1_ack,
  output logic        r1_err,
  output logic [31:0] r1_rdata,
  output logic        m_re,
  output logic        m_we,
  output logic [1:0]  m_asize,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  input  logic [31:0] m_rdata,
  output logic [1:0]  dbg_state_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_e;

  state_e      state_q;
  logic [3:0]  cnt_q;
  logic        port_q;
  logic        we_q;
  logic        err_q;
  logic        r0_ack_q;
  logic        r0_err_q;
  logic [31:0] r0_rdata_q;
  logic        r1_ack_q;
  logic        r1_err_q;
  logic [31:0] r1_rdata_q;
  logic        m_re_q;
  logic        m_we_q;
  logic [1:0]  m_asize_q;
  logic [31:0] m_addr_q;
  logic [31:0] m_wdata_q;
`ifdef AXO_ARB_ROUND_ROBIN_EN
  logic        last_grant_q;
`endif

  logic        grant_d;
  logic        sel_we;
  logic [1:0]  sel_asize;
  logic [31:0] sel_addr;
  logic [31:0] sel_wdata;
  logic        sel_err;
  logic [31:0] done_rdata;

  // Pick the winning port, mux its request fields and classify alignment.
  always_comb begin
    grant_d = ~r0_req;
`ifdef AXO_ARB_ROUND_ROBIN_EN
    if (r0_req && r1_req) begin
      grant_d = ~last_grant_q;
    end
`endif
    sel_we    = grant_d ? r1_we    : r0_we;
    sel_asize = grant_d ? r1_asize : r0_asize;
    sel_addr  = grant_d ? r1_addr  : r0_addr;
    sel_wdata = grant_d ? r1_wdata : r0_wdata;
    sel_err   = (sel_asize == 2'd3) ||
                ((sel_asize == 2'd1) && sel_addr[0]) ||
                ((sel_asize == 2'd2) && (sel_addr[1:0] != 2'b00));
  end

  // In DONE the bus data is valid and is forwarded straight to the winner; writes and errors return 0.
  assign done_rdata = (!we_q && !err_q) ? m_rdata : 32'h0;

  // Outside its ack cycle, each port keeps showing the data from its last completion.
  assign r0_rdata = r0_ack_q ? done_rdata : r0_rdata_q;
  assign r1_rdata = r1_ack_q ? done_rdata : r1_rdata_q;

  assign r0_ack      = r0_ack_q;
  assign r0_err      = r0_err_q;
  assign r1_ack      = r1_ack_q;
  assign r1_err      = r1_err_q;
  assign m_re        = m_re_q;
  assign m_we        = m_we_q;
  assign m_asize     = m_asize_q;
  assign m_addr      = m_addr_q;
  assign m_wdata     = m_wdata_q;
  assign dbg_state_o = state_q;

  // Sequencer FSM with registered bus strobes and ack/err pulses; async reset aborts any transfer.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      cnt_q      <= 4'd0;
      port_q     <= 1'b0;
      we_q       <= 1'b0;
      err_q      <= 1'b0;
      r0_ack_q   <= 1'b0;
      r0_err_q   <= 1'b0;
      r0_rdata_q <= 32'h0;
      r1_ack_q   <= 1'b0;
      r1_err_q   <= 1'b0;
      r1_rdata_q <= 32'h0;
      m_re_q     <= 1'b0;
      m_we_q     <= 1'b0;
      m_asize_q  <= 2'd0;
      m_addr_q   <= 32'h0;
      m_wdata_q  <= 32'h0;
`ifdef AXO_ARB_ROUND_ROBIN_EN
      last_grant_q <= 1'b1;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (r0_req || r1_req) begin
            port_q <= grant_d;
            we_q   <= sel_we;
            err_q  <= sel_err;
`ifdef AXO_ARB_ROUND_ROBIN_EN
            last_grant_q <= grant_d;
`endif
            if (sel_err) begin
              // Rejected access: skip the bus and report the error on the next cycle.
              state_q  <= DONE;
              r0_ack_q <= ~grant_d;
              r0_err_q <= ~grant_d;
              r1_ack_q <= grant_d;
              r1_err_q <= grant_d;
            end else begin
              state_q   <= ISSUE;
              m_re_q    <= ~sel_we;
              m_we_q    <= sel_we;
              m_asize_q <= sel_asize;
              m_addr_q  <= sel_addr;
              m_wdata_q <= sel_wdata;
            end
          end
        end
        ISSUE: begin
          // The bus is driven for exactly this one cycle.
          m_re_q    <= 1'b0;
          m_we_q    <= 1'b0;
          m_asize_q <= 2'd0;
          m_addr_q  <= 32'h0;
          m_wdata_q <= 32'h0;
          cnt_q     <= 4'(LATENCY - 1);
          if (LATENCY == 1) begin
            state_q  <= DONE;
            r0_ack_q <= ~port_q;
            r1_ack_q <= port_q;
          end else begin
            state_q <= WAIT;
          end
        end
        WAIT: begin
          cnt_q <= cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            state_q  <= DONE;
            r0_ack_q <= ~port_q;
            r1_ack_q <= port_q;
          end
        end
        DONE: begin
          // Hold the delivered data for the winner; the loser's outputs are left untouched.
          if (r0_ack_q) begin
            r0_rdata_q <= done_rdata;
          end
          if (r1_ack_q) begin
            r1_rdata_q <= done_rdata;
          end
          r0_ack_q <= 1'b0;
          r0_err_q <= 1'b0;
          r1_ack_q <= 1'b0;
          r1_err_q <= 1'b0;
          state_q  <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule
